// File: rtl/wr_resp_dir_buffer.sv
// Write-response direction buffer.
// One independent FIFO per response direction. Pushes arrive from the direction
// decoder (multi-hot legal); each FIFO drains toward the master with a valid/ready
// handshake. Outputs come only from registered state; there is no push-to-output bypass.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst            - asynchronous active-high reset
//   v_in_vld       - per-direction push strobe
//   v_in_pld       - per-direction push payload (txnid, sideband)
//   v_out_vld      - per-direction head valid (count != 0)
//   v_out_pld      - per-direction head payload, zero when not valid
//   v_out_rdy      - per-direction master ready
//   v_almost_full  - per-direction count >= DEPTH-1
//   v_count        - per-direction occupancy
//   v_err_overflow - per-direction sticky overflow (push dropped while full)

package wr_resp_pkg;
   typedef struct packed {
      logic [7:0] txnid;
      logic [3:0] sideband;
   } wr_resp_pld_t;
endpackage

module wr_resp_dir_buffer
   import wr_resp_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic         [WIDTH-1:0]      v_in_vld,
   input  wr_resp_pld_t [WIDTH-1:0]      v_in_pld,
   output logic         [WIDTH-1:0]      v_out_vld,
   output wr_resp_pld_t [WIDTH-1:0]      v_out_pld,
   input  logic         [WIDTH-1:0]      v_out_rdy,
   output logic         [WIDTH-1:0]      v_almost_full,
   output logic         [WIDTH-1:0][CW-1:0] v_count,
   output logic         [WIDTH-1:0]      v_err_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   for (genvar i = 0; i < WIDTH; i++) begin : gen_dir
      logic [AW-1:0] wptr_q, wptr_d;
      logic [AW-1:0] rptr_q, rptr_d;
      logic [CW-1:0] count_q, count_d;
      logic          err_q, err_d;
      wr_resp_pld_t  mem_q [DEPTH];

      logic pop, full, push_acc, ovf;

      assign pop      = (count_q != '0) && v_out_rdy[i];
      assign full     = (count_q == CW'(DEPTH));
      // A full FIFO still accepts a push when the head leaves on the same edge.
      assign push_acc = v_in_vld[i] && (!full || pop);
      assign ovf      = v_in_vld[i] && full && !pop;

      always_comb begin
         wptr_d  = wptr_q;
         rptr_d  = rptr_q;
         count_d = count_q;
         err_d   = err_q | ovf;
         // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
         if (push_acc) wptr_d = wptr_q + AW'(1);
         if (pop)      rptr_d = rptr_q + AW'(1);
         unique case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
         end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
         end
      end

      // Storage is not reset; stale contents are hidden by the zero-gated output.
      always_ff @(posedge clk) begin
         if (push_acc) mem_q[wptr_q] <= v_in_pld[i];
      end

      assign v_out_vld[i]      = (count_q != '0);
      assign v_out_pld[i]      = (count_q != '0) ? mem_q[rptr_q] : '0;
      assign v_almost_full[i]  = (count_q >= CW'(DEPTH - 1));
      assign v_count[i]        = count_q;
      assign v_err_overflow[i] = err_q;
   end

endmodule

// File: tb/tb_wr_resp_dir_buffer.sv
// Self-checking bench for wr_resp_dir_buffer: per-direction scoreboard queues are
// filled when pushes are driven and compared against the head when the DUT presents it.
module tb_wr_resp_dir_buffer;
   import wr_resp_pkg::*;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic                            clk = 1'b0;
   logic                            rst;
   logic         [WIDTH-1:0]        v_in_vld;
   wr_resp_pld_t [WIDTH-1:0]        v_in_pld;
   logic         [WIDTH-1:0]        v_out_vld;
   wr_resp_pld_t [WIDTH-1:0]        v_out_pld;
   logic         [WIDTH-1:0]        v_out_rdy;
   logic         [WIDTH-1:0]        v_almost_full;
   logic         [WIDTH-1:0][CW-1:0] v_count;
   logic         [WIDTH-1:0]        v_err_overflow;

   wr_resp_dir_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .v_in_vld       (v_in_vld),
      .v_in_pld       (v_in_pld),
      .v_out_vld      (v_out_vld),
      .v_out_pld      (v_out_pld),
      .v_out_rdy      (v_out_rdy),
      .v_almost_full  (v_almost_full),
      .v_count        (v_count),
      .v_err_overflow (v_err_overflow)
   );

   always #5 clk = ~clk;

   int unsigned  n_checks = 0;
   int unsigned  n_errors = 0;
   wr_resp_pld_t sb_q [WIDTH][$];
   logic [WIDTH-1:0] err_m = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic wr_resp_pld_t mk(input logic [7:0] id, input logic [3:0] sb);
      wr_resp_pld_t p;
      p.txnid    = id;
      p.sideband = sb;
      return p;
   endfunction

   // Compare every output against the model; the head is compared whenever valid.
   task automatic check_outputs();
      for (int i = 0; i < WIDTH; i++) begin
         int unsigned  sz;
         wr_resp_pld_t exp_pld;
         sz      = sb_q[i].size();
         exp_pld = (sz != 0) ? sb_q[i][0] : '0;
         check_eq($sformatf("count[%0d]", i), 32'(v_count[i]), sz);
         check_eq($sformatf("vld[%0d]", i), 32'(v_out_vld[i]), 32'(sz != 0));
         check_eq($sformatf("afull[%0d]", i), 32'(v_almost_full[i]), 32'(sz >= DEPTH - 1));
         check_eq($sformatf("err[%0d]", i), 32'(v_err_overflow[i]), 32'(err_m[i]));
         check_eq($sformatf("pld[%0d]", i), 32'(v_out_pld[i]), 32'(exp_pld));
      end
   endtask

   // Called at a falling edge: check, drive, update model, advance one cycle.
   task automatic cycle(input logic [WIDTH-1:0] vld, input wr_resp_pld_t [WIDTH-1:0] pld,
                        input logic [WIDTH-1:0] rdy);
      check_outputs();
      v_in_vld  = vld;
      v_in_pld  = pld;
      v_out_rdy = rdy;
      for (int i = 0; i < WIDTH; i++) begin
         if (sb_q[i].size() != 0 && rdy[i]) void'(sb_q[i].pop_front());
         if (vld[i]) begin
            if (sb_q[i].size() < DEPTH) sb_q[i].push_back(pld[i]);
            else err_m[i] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [WIDTH-1:0] rdy);
      for (int k = 0; k < n; k++) cycle('0, '0, rdy);
   endtask

   wr_resp_pld_t [WIDTH-1:0] p;

   initial begin
      rst       = 1'b1;
      v_in_vld  = '0;
      v_in_pld  = '0;
      v_out_rdy = '0;
      repeat (2) @(negedge clk);
      check_outputs();
      rst = 1'b0;

      // Single push on dir2 with ready high.
      p = '0; p[2] = mk(8'h12, 4'h3);
      cycle(4'b0100, p, 4'b1111);
      idle(2, 4'b1111);

      // Fill dir0 with 1..4 while blocked, then overflow with a fifth push.
      for (int k = 1; k <= 4; k++) begin
         p = '0; p[0] = mk(8'(k), 4'(k));
         cycle(4'b0001, p, 4'b0000);
      end
      idle(1, 4'b0000);
      p = '0; p[0] = mk(8'h05, 4'h5);
      cycle(4'b0001, p, 4'b0000);
      idle(1, 4'b0000);
      idle(5, 4'b0001);

      // Fill dir1 then push 0x20 while popping the head: no overflow.
      for (int k = 0; k < 4; k++) begin
         p = '0; p[1] = mk(8'h1A + 8'(k), 4'h1);
         cycle(4'b0010, p, 4'b0000);
      end
      p = '0; p[1] = mk(8'h20, 4'h2);
      cycle(4'b0010, p, 4'b0010);
      idle(1, 4'b0000);
      idle(5, 4'b0010);

      // All four directions in the same cycle.
      for (int i = 0; i < WIDTH; i++) p[i] = mk(8'h40 + 8'(i), 4'(i));
      cycle(4'b1111, p, 4'b0000);
      idle(1, 4'b0000);
      idle(2, 4'b1111);

      // Random traffic.
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < WIDTH; i++) p[i] = wr_resp_pld_t'(12'($urandom));
         cycle(4'($urandom), p, 4'($urandom));
      end
      idle(5, 4'b1111);

      // Reset with three entries queued on dir3.
      for (int k = 0; k < 3; k++) begin
         p = '0; p[3] = mk(8'h30 + 8'(k), 4'h3);
         cycle(4'b1000, p, 4'b0000);
      end
      check_outputs();
      #2;
      rst       = 1'b1;
      v_in_vld  = 4'b1000;
      v_out_rdy = 4'b1111;
      #1;
      for (int i = 0; i < WIDTH; i++) sb_q[i].delete();
      err_m = '0;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      p = '0; p[3] = mk(8'h33, 4'h7);
      cycle(4'b1000, p, 4'b0000);
      idle(1, 4'b0000);
      idle(2, 4'b1111);
      check_outputs();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/wr_resp_dir_buffer.md
WR_RESP_DIR_BUFFER -- requirements
Module: wr_resp_dir_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of response directions.
REQ-002 SHALL have parameter DEPTH, default 4, entries per direction queue; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port v_in_vld  input  WIDTH  per-direction write-response push strobe, from the direction decoder.
REQ-006 SHALL have port v_in_pld  input  wr_resp_pld_t[WIDTH]  per-direction payload (txnid, sideband).
REQ-007 SHALL have port v_out_vld  output  WIDTH  per-direction response valid toward the master.
REQ-008 SHALL have port v_out_pld  output  wr_resp_pld_t[WIDTH]  per-direction response payload.
REQ-009 SHALL have port v_out_rdy  input  WIDTH  per-direction master ready.
REQ-010 SHALL have port v_almost_full  output  WIDTH  per-direction throttle: count >= DEPTH-1.
REQ-011 SHALL have port v_count  output  WIDTH x $clog2(DEPTH+1)  per-direction occupancy.
REQ-012 SHALL have port v_err_overflow  output  WIDTH  sticky per-direction overflow flag.

Function
REQ-013 SHALL implement one independent FIFO per direction; multi-hot v_in_vld SHALL be legal and each bit SHALL affect only its own FIFO.
REQ-014 SHALL push: v_in_vld[i] writes v_in_pld[i] at the write pointer on the next edge when accepted.
REQ-015 SHALL pop: handshake v_out_vld[i] && v_out_rdy[i] removes the head entry on that edge.
REQ-016 SHALL accept a push when count[i] < DEPTH, or when count[i] == DEPTH and a pop occurs the same cycle.
REQ-017 SHALL, on push while full without pop, drop the payload, leave the FIFO unchanged, and set v_err_overflow[i] on the next edge.
REQ-018 SHALL hold v_err_overflow[i] set until reset; it SHALL have no other clear.
REQ-019 SHALL drive v_out_vld[i] = (count[i] != 0), purely from registered state; no combinational path from v_in_* to v_out_*.
REQ-020 SHALL have push-to-output latency of exactly one cycle: entry pushed at edge N is visible at v_out_* after edge N (no bypass).
REQ-021 SHALL drive v_out_pld[i] = head entry when v_out_vld[i]=1, and all-zero when v_out_vld[i]=0.
REQ-022 SHALL keep v_out_pld[i] stable while v_out_vld[i]=1 and v_out_rdy[i]=0.
REQ-023 SHALL ignore v_out_rdy[i] when v_out_vld[i]=0 (no pointer or count change).
REQ-024 SHALL update count[i] as +1 push-only, -1 pop-only, unchanged on simultaneous push and pop; count never exceeds DEPTH or goes below 0.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL preserve per-direction order: responses leave in push order.
REQ-027 SHALL compute v_almost_full[i] and v_count[i] from registered count (no same-cycle input dependency).

Reset
REQ-028 SHALL, on rst asserted, clear all pointers and counts asynchronously: v_out_vld=0, v_out_pld=0, v_count=0, v_almost_full=0, v_err_overflow=0.
REQ-029 SHALL discard all queued entries on reset mid-operation; pushes and pops in reset cycles SHALL be ignored.
REQ-030 SHALL not require storage-array reset; outputs stay zero-gated per REQ-021.

Verification
REQ-031 SHALL cover: single push dir2 txnid=0x12, rdy=1 -> v_out_vld[2]=1 one cycle later with txnid 0x12, popped next edge, count back to 0.
REQ-032 SHALL cover: 4 pushes dir0 txnids 1,2,3,4 with rdy=0 -> count=4, almost_full=1 at count 3; release rdy -> outputs 1,2,3,4 in order.
REQ-033 SHALL cover: fifth push dir0 while full, rdy=0 -> payload dropped, err_overflow[0]=1 sticky, count stays 4.
REQ-034 SHALL cover: full dir1 with simultaneous push 0x20 and pop -> no overflow, count stays 4, 0x20 emerges last.
REQ-035 SHALL cover: v_in_vld=4'b1111 same cycle -> all four counts=1, each direction's payload matches its input.
REQ-036 SHALL cover: rst asserted with count=3 on dir3 -> vld, count, err cleared immediately; post-reset push appears after one cycle.
